// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, pixel types and sprite step helpers
package vga_pkg;

   localparam int H_TOTAL     = 1904;
   localparam int V_TOTAL     = 932;
   localparam int H_ACT_START = 384;
   localparam int H_ACT_END   = 1823;
   localparam int V_ACT_START = 31;
   localparam int V_ACT_END   = 930;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_t;

   localparam logic [3:0] BG_LEVEL   = 4'b0100;
   localparam rgb444_t    SPRITE_RGB = '{r: 4'hF, g: 4'hF, b: 4'h0};

   // dir: bit0 = increment, bit1 = decrement; both or neither holds.
   // The extra top bit flags a decrement that went below zero.
   function automatic logic [12:0] step_sum(input logic [11:0] pos, input logic [1:0] dir,
                                            input logic [11:0] step);
      case (dir)
         2'b01:   return {1'b0, pos} + {1'b0, step};
         2'b10:   return {1'b0, pos} - {1'b0, step};
         default: return {1'b0, pos};
      endcase
   endfunction

   function automatic logic step_out_of_range(input logic [12:0] sum, input logic [11:0] lim);
      return sum[12] || (sum[11:0] > lim);
   endfunction

   function automatic logic [11:0] step_clamp(input logic [12:0] sum, input logic [11:0] lim);
      if (sum[12])
         return 12'd0;
      if (sum[11:0] > lim)
         return lim;
      return sum[11:0];
   endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - parameterised-width 2-flop synchroniser for asynchronous inputs
module btn_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vga_sprite_mover.sv
// rtl/vga_sprite_mover.sv - square sprite over switch background, 2-cycle RGB/sync pipeline
// Define SPRITE_AUTO_EN to compile in the idle-triggered auto-bounce mode.
module vga_sprite_mover
   import vga_pkg::*;
#(
   parameter int SPRITE_SIZE = 64,
   parameter int STEP        = 4,
   parameter int IDLE_FRAMES = 256
) (
   input  logic        pixclk,
   input  logic        rst,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [3:0]  btn,
   input  logic [2:0]  sw,
   output logic [3:0]  pix_r,
   output logic [3:0]  pix_g,
   output logic [3:0]  pix_b,
   output logic        hsync,
   output logic        vsync
);
   localparam logic [11:0] X_MAX  = 12'(H_ACT_END - H_ACT_START + 1 - SPRITE_SIZE);
   localparam logic [11:0] Y_MAX  = 12'(V_ACT_END - V_ACT_START + 1 - SPRITE_SIZE);
   localparam logic [11:0] STEP_W = 12'(STEP);
   localparam logic [11:0] SIZE_W = 12'(SPRITE_SIZE);

   logic [3:0]  btn_s;
   logic [10:0] spr_x;
   logic [9:0]  spr_y;
   logic        tick;
   logic [12:0] man_sx, man_sy;

   btn_sync #(.WIDTH(4)) u_btn_sync (
      .clk (pixclk),
      .rst (rst),
      .d   (btn),
      .q   (btn_s)
   );

   assign tick = (hcount == 11'd0) && (vcount == 10'(V_TOTAL - 1));

   // btn = {right, left, down, up}; opposing buttons map to dir 2'b11 and cancel.
   always_comb begin
      man_sx = step_sum({1'b0, spr_x}, {btn_s[2], btn_s[3]}, STEP_W);
      man_sy = step_sum({2'b0, spr_y}, {btn_s[0], btn_s[1]}, STEP_W);
   end

`ifdef SPRITE_AUTO_EN
   mode_t       mode;
   logic        dx, dy;
   logic [7:0]  idle_cnt;
   logic [12:0] auto_sx, auto_sy;

   always_comb begin
      auto_sx = step_sum({1'b0, spr_x}, dx ? 2'b01 : 2'b10, STEP_W);
      auto_sy = step_sum({2'b0, spr_y}, dy ? 2'b01 : 2'b10, STEP_W);
   end

   always_ff @(posedge pixclk) begin
      if (rst) begin
         mode     <= MANUAL;
         dx       <= 1'b1;
         dy       <= 1'b1;
         idle_cnt <= '0;
         spr_x    <= 11'(X_MAX >> 1);
         spr_y    <= 10'(Y_MAX >> 1);
      end else if (tick) begin
         if (mode == AUTO && btn_s == 4'd0) begin
            spr_x <= 11'(step_clamp(auto_sx, X_MAX));
            spr_y <= 10'(step_clamp(auto_sy, Y_MAX));
            if (step_out_of_range(auto_sx, X_MAX))
               dx <= ~dx;
            if (step_out_of_range(auto_sy, Y_MAX))
               dy <= ~dy;
         end else begin
            // Any press in AUTO drops straight back to MANUAL and moves by MANUAL rules.
            spr_x <= 11'(step_clamp(man_sx, X_MAX));
            spr_y <= 10'(step_clamp(man_sy, Y_MAX));
            mode  <= MANUAL;
            if (btn_s != 4'd0) begin
               idle_cnt <= '0;
            end else if (idle_cnt == 8'(IDLE_FRAMES - 1)) begin
               mode     <= AUTO;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 8'd1;
            end
         end
      end
   end
`else
   always_ff @(posedge pixclk) begin
      if (rst) begin
         spr_x <= 11'(X_MAX >> 1);
         spr_y <= 10'(Y_MAX >> 1);
      end else if (tick) begin
         spr_x <= 11'(step_clamp(man_sx, X_MAX));
         spr_y <= 10'(step_clamp(man_sy, Y_MAX));
      end
   end
`endif

   logic [11:0] px, py;
   logic        act, in_spr;
   logic        s1_act, s1_spr, s1_hs, s1_vs;
   logic [2:0]  s1_sw;
   rgb444_t     colour, pix;

   // px/py wrap outside the active area, but act masks them there.
   always_comb begin
      px     = {1'b0, hcount} - 12'(H_ACT_START);
      py     = {2'b0, vcount} - 12'(V_ACT_START);
      act    = (hcount >= 11'(H_ACT_START)) && (hcount <= 11'(H_ACT_END)) &&
               (vcount >= 10'(V_ACT_START)) && (vcount <= 10'(V_ACT_END));
      in_spr = (px >= {1'b0, spr_x}) && (px < {1'b0, spr_x} + SIZE_W) &&
               (py >= {2'b0, spr_y}) && (py < {2'b0, spr_y} + SIZE_W);
   end

   always_comb begin
      colour = '0;
      if (s1_act) begin
         if (s1_spr) begin
            colour = SPRITE_RGB;
         end else begin
            colour.r = s1_sw[0] ? BG_LEVEL : 4'h0;
            colour.g = s1_sw[1] ? BG_LEVEL : 4'h0;
            colour.b = s1_sw[2] ? BG_LEVEL : 4'h0;
         end
      end
   end

   always_ff @(posedge pixclk) begin
      if (rst) begin
         s1_act <= 1'b0;
         s1_spr <= 1'b0;
         s1_sw  <= '0;
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         pix    <= '0;
         hsync  <= 1'b0;
         vsync  <= 1'b0;
      end else begin
         s1_act <= act;
         s1_spr <= in_spr;
         s1_sw  <= sw;
         s1_hs  <= hsync_in;
         s1_vs  <= vsync_in;
         pix    <= colour;
         hsync  <= s1_hs;
         vsync  <= s1_vs;
      end
   end

   assign pix_r = pix.r;
   assign pix_g = pix.g;
   assign pix_b = pix.b;

endmodule

// File: tb/tb_vga_sprite_mover.sv
// tb/tb_vga_sprite_mover.sv - randomized scoreboard bench for vga_sprite_mover
// Exercises the SPRITE_AUTO_EN checks when that macro is defined.
module tb_vga_sprite_mover;

   localparam int H_ACT0 = 384;
   localparam int V_ACT0 = 31;
   localparam int ACT_W  = 1440;
   localparam int ACT_H  = 900;
   localparam int SIZE   = 64;
   localparam int STEP   = 4;
   localparam int X_MAX  = ACT_W - SIZE;
   localparam int Y_MAX  = ACT_H - SIZE;
   localparam int V_TICK = 931;

   logic        pixclk = 1'b0;
   logic        rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync_in, vsync_in;
   logic [3:0]  btn;
   logic [2:0]  sw, sw_next;
   logic [3:0]  pix_r, pix_g, pix_b;
   logic        hsync, vsync;

   always #5 pixclk = ~pixclk;

   vga_sprite_mover dut (
      .pixclk   (pixclk),
      .rst      (rst),
      .hcount   (hcount),
      .vcount   (vcount),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .btn      (btn),
      .sw       (sw),
      .pix_r    (pix_r),
      .pix_g    (pix_g),
      .pix_b    (pix_b),
      .hsync    (hsync),
      .vsync    (vsync)
   );

   int mx, my, mdx, mdy;
   bit m_auto;
`ifdef SPRITE_AUTO_EN
   int idle;
`endif
   logic [13:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic int clampi(int v, int lo, int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      mx = X_MAX / 2;
      my = Y_MAX / 2;
      mdx = 1;
      mdy = 1;
      m_auto = 1'b0;
`ifdef SPRITE_AUTO_EN
      idle = 0;
`endif
   endtask

   task automatic model_tick(logic [3:0] b);
      if (m_auto && b == 4'd0) begin
         mx += STEP * mdx;
         if (mx > X_MAX) begin mx = X_MAX; mdx = -mdx; end
         else if (mx < 0) begin mx = 0; mdx = -mdx; end
         my += STEP * mdy;
         if (my > Y_MAX) begin my = Y_MAX; mdy = -mdy; end
         else if (my < 0) begin my = 0; mdy = -mdy; end
      end else begin
         mx = clampi(mx + STEP * (int'(b[3]) - int'(b[2])), 0, X_MAX);
         my = clampi(my + STEP * (int'(b[1]) - int'(b[0])), 0, Y_MAX);
         m_auto = 1'b0;
`ifdef SPRITE_AUTO_EN
         if (b != 4'd0) begin
            idle = 0;
         end else begin
            idle++;
            if (idle == 256) begin m_auto = 1'b1; idle = 0; end
         end
`endif
      end
   endtask

   function automatic logic [13:0] expect_out(int h, int v, logic hs, logic vs);
      int x, y;
      logic [3:0] r, g, b;
      x = h - H_ACT0;
      y = v - V_ACT0;
      r = 4'h0; g = 4'h0; b = 4'h0;
      if (x >= 0 && x < ACT_W && y >= 0 && y < ACT_H) begin
         if (x >= mx && x < mx + SIZE && y >= my && y < my + SIZE) begin
            r = 4'hF; g = 4'hF;
         end else begin
            r = sw[0] ? 4'h4 : 4'h0;
            g = sw[1] ? 4'h4 : 4'h0;
            b = sw[2] ? 4'h4 : 4'h0;
         end
      end
      return {r, g, b, hs, vs};
   endfunction

   task automatic drive(int h, int v, bit r);
      @(negedge pixclk);
      hcount   = 11'(h);
      vcount   = 10'(v);
      rst      = r;
      sw       = sw_next;
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      if (r) begin
         if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
         exp_q.push_back('0);
         model_reset();
      end else begin
         exp_q.push_back(expect_out(h, v, hsync_in, vsync_in));
         if (h == 0 && v == V_TICK) model_tick(btn);
      end
   endtask

   task automatic drive_rand();
      int h, v;
      if ($urandom_range(0, 1) == 1) begin
         h = H_ACT0 + mx + int'($urandom_range(0, 79)) - 8;
         v = clampi(V_ACT0 + my + int'($urandom_range(0, 79)) - 8, 0, 930);
      end else begin
         h = int'($urandom_range(0, 1903));
         v = int'($urandom_range(0, 930));
      end
      drive(h, v, 1'b0);
   endtask

   task automatic frame(logic [3:0] b);
      btn = b;
      repeat (2 + $urandom_range(0, 3)) drive_rand();
      drive(0, V_TICK, 1'b0);
   endtask

   task automatic check_val(string name, int got, int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic check_state(string name);
      @(posedge pixclk);
      #1;
      check_val({name, "_x"}, int'(dut.spr_x), mx);
      check_val({name, "_y"}, int'(dut.spr_y), my);
`ifdef SPRITE_AUTO_EN
      check_val({name, "_mode"}, int'(dut.mode), int'(m_auto));
`endif
   endtask

   task automatic sweep_edges();
      int offs[4] = '{-1, 0, 63, 64};
      foreach (offs[i]) begin
         foreach (offs[j]) begin
            drive(H_ACT0 + mx + offs[i], clampi(V_ACT0 + my + offs[j], 0, 930), 1'b0);
         end
      end
   endtask

   initial begin
      logic [13:0] e, got;
      forever begin
         @(posedge pixclk);
         #1;
         if (exp_q.size() >= 2) begin
            e   = exp_q.pop_front();
            got = {pix_r, pix_g, pix_b, hsync, vsync};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL pix_out @%0t: got %h expected %h ({r,g,b,hs,vs})", $time, got, e);
            end
         end
      end
   end

   initial begin
      int hb[4] = '{383, 384, 1823, 1824};
      int vb[3] = '{30, 31, 930};
      logic [3:0] b;
      rst = 1'b1; hcount = '0; vcount = '0; hsync_in = 1'b0; vsync_in = 1'b0;
      btn = 4'd0; sw = 3'b101; sw_next = 3'b101;
      model_reset();

      drive(100, 100, 1'b1);
      drive(100, 100, 1'b1);
      drive(1072, 449, 1'b0);
      drive(500, 100, 1'b0);
      drive(100, 100, 1'b0);
      foreach (hb[i]) foreach (vb[j]) drive(hb[i], vb[j], 1'b0);
      sweep_edges();
      check_state("after_reset");

`ifdef SPRITE_AUTO_EN
      repeat (256) frame(4'b0000);
      check_state("idle_to_auto");
      frame(4'b0000);
      check_state("auto_first");
      repeat (260) frame(4'b0000);
      check_state("auto_bounce");
      sweep_edges();
      frame(4'b0001);
      check_state("auto_exit");
`endif

      drive(700, 200, 1'b0);
      drive(701, 200, 1'b1);
      drive(702, 200, 1'b0);
      drive(703, 200, 1'b0);
      drive(704, 200, 1'b0);
      check_state("reset_mid_line");

      repeat (3) frame(4'b1000);
      check_state("right3");
      repeat (2) frame(4'b1100);
      check_state("left_right_cancel");
      repeat (110) frame(4'b0001);
      check_state("top_clamp");
      repeat (175) frame(4'b1000);
      check_state("right_clamp");
      sweep_edges();

      for (int k = 0; k < 300; k++) begin
         if ((k % 10) == 0) sw_next = 3'($urandom);
         b = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
         frame(b);
         if ((k % 25) == 0) begin
            check_state("random");
            sweep_edges();
         end
      end

      drive(900, 500, 1'b1);
      drive(901, 500, 1'b0);
      drive(902, 500, 1'b0);
      check_state("final_reset");
      repeat (4) drive_rand();
      @(posedge pixclk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
